dmem_arbiter: RTL and testbench

Two-requester arbiter for the shared single-port 16-bit data memory. The requesters are the CPU load/store path and a DMA/loader engine. It picks at most one access per cycle and drives the memory port. It returns read data to the owning requester one cycle later, and supplies the CPU stall signal that freezes the PC while the CPU is refused. The CPU has fixed priority, backed by a DMA lock mechanism and an optional starvation guard.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, DMA and memory port bundle for dmem_arbiter
// slave is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_stall;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;

   logic          dma_req;
   logic          dma_we;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata;
   logic          dma_lock;
   logic          dma_gnt;
   logic          dma_rvalid;
   logic [DW-1:0] dma_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter for the single-port data memory
// Optional DMA starvation guard enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
   parameter int AW           = 16,
   parameter int DW           = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus
);

   typedef enum logic {
      FREE       = 1'b0,
      DMA_LOCKED = 1'b1
   } ownState_t;

   ownState_t state;
   ownState_t stateNext;

   logic cpuWin;
   logic dmaWin;
   logic starveHit;
   logic rdPend;
   logic rdOwner;
   logic cpuRet;
   logic dmaRet;

`ifdef DMEM_ARB_STARVE_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LimitVal = CW'(STARVE_LIMIT);

   logic [CW-1:0] starveCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starveCnt <= '0;
      end else if (!bus.dma_req || dmaWin) begin
         starveCnt <= '0;
      end else if (starveCnt != LimitVal) begin
         starveCnt <= starveCnt + 1'b1;
      end
   end

   assign starveHit = (starveCnt == LimitVal);
`else
   logic unusedStarveLimit;
   assign unusedStarveLimit = ^STARVE_LIMIT;
   assign starveHit         = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FREE;
      end else begin
         state <= stateNext;
      end
   end

   // Grants stay low through reset so the memory never sees a stray strobe.
   always_comb begin
      stateNext = state;
      cpuWin    = 1'b0;
      dmaWin    = 1'b0;
      if (!rst) begin
         case (state)
            FREE: begin
               if (bus.dma_req && starveHit) begin
                  dmaWin = 1'b1;
               end else if (bus.cpu_req) begin
                  cpuWin = 1'b1;
               end else if (bus.dma_req) begin
                  dmaWin = 1'b1;
               end
               if (dmaWin && bus.dma_lock) begin
                  stateNext = DMA_LOCKED;
               end
            end
            DMA_LOCKED: begin
               // The release cycle still excludes the CPU; it competes from the next one.
               dmaWin = bus.dma_req;
               if (!bus.dma_lock) begin
                  stateNext = FREE;
               end
            end
            default: begin
               stateNext = FREE;
            end
         endcase
      end
   end

   assign bus.cpu_gnt   = cpuWin;
   assign bus.dma_gnt   = dmaWin;
   assign bus.cpu_stall = bus.cpu_req & ~cpuWin & ~rst;

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (cpuWin) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.cpu_we;
         bus.mem_addr  = bus.cpu_addr;
         bus.mem_wdata = bus.cpu_wdata;
      end else if (dmaWin) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.dma_we;
         bus.mem_addr  = bus.dma_addr;
         bus.mem_wdata = bus.dma_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPend  <= 1'b0;
         rdOwner <= 1'b0;
      end else begin
         rdPend  <= (cpuWin & ~bus.cpu_we) | (dmaWin & ~bus.dma_we);
         rdOwner <= dmaWin;
      end
   end

   assign cpuRet = rdPend & ~rdOwner & ~rst;
   assign dmaRet = rdPend & rdOwner & ~rst;

   assign bus.cpu_rvalid = cpuRet;
   assign bus.dma_rvalid = dmaRet;
   assign bus.cpu_rdata  = cpuRet ? bus.mem_rdata : '0;
   assign bus.dma_rdata  = dmaRet ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter against a cycle-level reference model
module tb_dmem_arbiter;
   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int LIMIT = 4;
`ifdef DMEM_ARB_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          rst;
      bit          cpuReq;
      bit          cpuWe;
      logic [15:0] cpuAddr;
      logic [15:0] cpuWdata;
      bit          dmaReq;
      bit          dmaWe;
      bit          dmaLock;
      logic [15:0] dmaAddr;
      logic [15:0] dmaWdata;
   } stim_t;

   typedef struct {
      logic        cg;
      logic        dg;
      logic        stall;
      logic        en;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } exp_t;

   typedef struct {
      bit          owner;
      logic [15:0] data;
      int          cyc;
   } rd_t;

   exp_t expQ[$];
   rd_t  readQ[$];

   logic [15:0] envMem [256];
   logic [15:0] refMem [256];

   int testsRun    = 0;
   int testsFailed = 0;
   int cycleCount  = 0;

   bit refLocked = 1'b0;
   int refStarve = 0;
   bit lastCg    = 1'b0;

   function automatic logic [15:0] initVal(int i);
      return (i == 16) ? 16'hBEEF : 16'(32'hA000 + i * 7);
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
      testsRun++;
      if (act !== expv) begin
         testsFailed++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cycleCount, act, expv);
      end
   endfunction

   function automatic stim_t mk(bit r, bit cr, bit cw, int ca, int cd,
                                bit dr, bit dw, int da, int dd, bit dl);
      stim_t s;
      s.rst      = r;
      s.cpuReq   = cr;
      s.cpuWe    = cw;
      s.cpuAddr  = 16'(ca);
      s.cpuWdata = 16'(cd);
      s.dmaReq   = dr;
      s.dmaWe    = dw;
      s.dmaAddr  = 16'(da);
      s.dmaWdata = 16'(dd);
      s.dmaLock  = dl;
      return s;
   endfunction

   // Environment memory: registered read, one access per cycle.
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) envMem[bus.mem_addr[7:0]] <= bus.mem_wdata;
         else            bus.mem_rdata <= envMem[bus.mem_addr[7:0]];
      end
   end

   // Applies one cycle of stimulus and predicts the arbiter's response from the ownership rules.
   task automatic applyCycle(input stim_t s);
      exp_t e;
      bit   cg;
      bit   dg;
      bit   forceDma;
      int   a;
      @(posedge clk);
      #1;
      cycleCount++;
      rst           = s.rst;
      bus.cpu_req   = s.cpuReq;
      bus.cpu_we    = s.cpuWe;
      bus.cpu_addr  = s.cpuAddr;
      bus.cpu_wdata = s.cpuWdata;
      bus.dma_req   = s.dmaReq;
      bus.dma_we    = s.dmaWe;
      bus.dma_addr  = s.dmaAddr;
      bus.dma_wdata = s.dmaWdata;
      bus.dma_lock  = s.dmaLock;

      cg = 1'b0;
      dg = 1'b0;
      e  = '{default: '0};
      if (s.rst) begin
         refLocked = 1'b0;
         refStarve = 0;
         readQ.delete();
      end else begin
         forceDma = STARVE_EN && !refLocked && s.dmaReq && (refStarve >= LIMIT);
         if (refLocked)    dg = s.dmaReq;
         else if (forceDma) dg = 1'b1;
         else if (s.cpuReq) cg = 1'b1;
         else if (s.dmaReq) dg = 1'b1;

         refLocked = refLocked ? s.dmaLock : (dg && s.dmaLock);
         if (!s.dmaReq || dg) refStarve = 0;
         else refStarve = (refStarve + 1 > LIMIT) ? LIMIT : refStarve + 1;

         e.cg    = cg;
         e.dg    = dg;
         e.stall = s.cpuReq && !cg;
         e.en    = cg || dg;
         if (cg) begin
            e.we = s.cpuWe; e.addr = s.cpuAddr; e.wdata = s.cpuWdata;
         end else if (dg) begin
            e.we = s.dmaWe; e.addr = s.dmaAddr; e.wdata = s.dmaWdata;
         end
         if (cg || dg) begin
            a = int'(e.addr[7:0]);
            if (e.we) refMem[a] = e.wdata;
            else readQ.push_back('{owner: dg, data: refMem[a], cyc: cycleCount + 1});
         end
      end
      lastCg = cg;
      expQ.push_back(e);
   endtask

   exp_t       monE;
   rd_t        monR;
   logic [1:0] monRv;
   bit         monHave;

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monE = expQ.pop_front();
         check("cpu_gnt",   32'(bus.cpu_gnt),   32'(monE.cg));
         check("dma_gnt",   32'(bus.dma_gnt),   32'(monE.dg));
         check("cpu_stall", 32'(bus.cpu_stall), 32'(monE.stall));
         check("mem_en",    32'(bus.mem_en),    32'(monE.en));
         check("mem_we",    32'(bus.mem_we),    32'(monE.we));
         check("mem_addr",  32'(bus.mem_addr),  32'(monE.addr));
         check("mem_wdata", 32'(bus.mem_wdata), 32'(monE.wdata));
      end
      monRv   = 2'b00;
      monHave = 1'b0;
      if (readQ.size() > 0 && readQ[0].cyc <= cycleCount) begin
         monR    = readQ.pop_front();
         monHave = 1'b1;
         monRv   = monR.owner ? 2'b01 : 2'b10;
      end
      check("rvalid{cpu,dma}", 32'({bus.cpu_rvalid, bus.dma_rvalid}), 32'(monRv));
      if (monHave) begin
         check("owner_rdata", 32'(monR.owner ? bus.dma_rdata : bus.cpu_rdata), 32'(monR.data));
         check("other_rdata", 32'(monR.owner ? bus.cpu_rdata : bus.dma_rdata), 32'd0);
      end
   end

   initial begin
      stim_t s;
      stim_t idle;
      for (int i = 0; i < 256; i++) begin
         envMem[i] = initVal(i);
         refMem[i] = initVal(i);
      end
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
      bus.dma_lock = 1'b0;
      bus.mem_rdata = '0;

      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) applyCycle(mk(1, 1, 0, 5, 0, 1, 0, 6, 0, 1));
      applyCycle(idle);

      // CPU read of 0x0010 returning 0xBEEF
      applyCycle(mk(0, 1, 0, 'h10, 0, 0, 0, 0, 0, 0));
      applyCycle(idle);

      // simultaneous requests: CPU first, DMA once CPU drops
      applyCycle(mk(0, 1, 0, 'h3, 0, 1, 0, 'h4, 0, 0));
      applyCycle(mk(0, 1, 1, 'h3, 'h55, 1, 0, 'h4, 0, 0));
      applyCycle(mk(0, 0, 0, 0, 0, 1, 0, 'h4, 0, 0));
      applyCycle(idle);

      // both held continuously
      repeat (7) applyCycle(mk(0, 1, 0, 'h7, 0, 1, 0, 'h8, 0, 0));
      applyCycle(idle);

      // locked DMA write of 0x1234 to 0x0020 while CPU waits
      applyCycle(mk(0, 0, 0, 0, 0, 1, 1, 'h20, 'h1234, 1));
      applyCycle(mk(0, 1, 0, 'h20, 0, 1, 1, 'h20, 'h1234, 1));
      applyCycle(mk(0, 1, 0, 'h20, 0, 1, 1, 'h20, 'h1234, 1));
      applyCycle(mk(0, 1, 0, 'h20, 0, 0, 0, 0, 0, 0));
      applyCycle(mk(0, 1, 0, 'h20, 0, 0, 0, 0, 0, 0));
      applyCycle(idle);

      // back-to-back reads
      applyCycle(mk(0, 1, 0, 'h1, 0, 0, 0, 0, 0, 0));
      applyCycle(mk(0, 0, 0, 0, 0, 1, 0, 'h2, 0, 0));
      applyCycle(idle);

      // reset during the read return cycle
      applyCycle(mk(0, 1, 0, 'h5, 0, 0, 0, 0, 0, 0));
      applyCycle(mk(1, 1, 0, 'h5, 0, 1, 0, 'h6, 0, 1));
      applyCycle(mk(1, 1, 0, 'h5, 0, 1, 0, 'h6, 0, 1));
      applyCycle(idle);

      // lock held with no DMA request keeps CPU stalled
      applyCycle(mk(0, 0, 0, 0, 0, 1, 0, 'h9, 0, 1));
      applyCycle(mk(0, 1, 0, 'hA, 0, 0, 0, 0, 0, 1));
      applyCycle(mk(0, 1, 0, 'hA, 0, 0, 0, 0, 0, 1));
      applyCycle(mk(0, 1, 0, 'hA, 0, 0, 0, 0, 0, 0));
      applyCycle(mk(0, 1, 0, 'hA, 0, 0, 0, 0, 0, 0));
      applyCycle(idle);

      s = idle;
      for (int n = 0; n < 3000; n++) begin
         if (!(s.cpuReq && !lastCg) || s.rst) begin
            s.cpuReq   = ($urandom_range(0, 99) < 55);
            s.cpuWe    = 1'($urandom_range(0, 1));
            s.cpuAddr  = 16'($urandom_range(0, 15));
            s.cpuWdata = 16'($urandom);
         end
         if (!(s.dmaReq && !dut.dmaWin) || s.rst) begin
            s.dmaReq   = ($urandom_range(0, 99) < 50);
            s.dmaWe    = 1'($urandom_range(0, 1));
            s.dmaAddr  = 16'($urandom_range(0, 15));
            s.dmaWdata = 16'($urandom);
         end
         s.dmaLock = ($urandom_range(0, 3) == 0);
         s.rst     = ($urandom_range(0, 199) == 0);
         applyCycle(s);
      end

      repeat (3) applyCycle(idle);
      @(negedge clk);
      #1;
      check("expq_drained",  32'(expQ.size()),  32'd0);
      check("readq_drained", 32'(readQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
